// File: rtl/issuequeue_mult.sv
// issuequeue_mult: age-ordered reservation station for the MULT unit with CDB wakeup and oldest-ready issue.
// Defining ISSUEQUEUE_MULT_FLUSH_EN adds a flush input that empties the queue.
module issuequeue_mult #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int DATA_W = 32,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ISSUEQUEUE_MULT_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              dispatch_en,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic              dispatch_rsready,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rtready,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              mult_stall,
  output logic              issuequeue_full,
  output logic [CW-1:0]     issuequeue_count,
  output logic              issuemult_enable,
  output logic [DATA_W-1:0] issuemult_rsdata,
  output logic [DATA_W-1:0] issuemult_rtdata,
  output logic [TAG_W-1:0]  issuemult_rdtag
);
  typedef struct packed {
    logic              v;
    logic              rs_rdy;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_rdy;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;
  entry_t q [DEPTH];
  entry_t wq [DEPTH];
  entry_t nq [DEPTH];
  entry_t din;
  logic [IW-1:0] sel, wr_idx;
  logic [CW-1:0] count_next;
  logic found, issue, accept, flush_c;
`ifdef ISSUEQUEUE_MULT_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif
  // wq holds entries after this cycle's wakeup; nq additionally applies compaction and dispatch
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (q[i].v && q[i].rs_rdy && q[i].rt_rdy) begin
        found = 1'b1;
        sel = IW'(i);
      end
    issue = found && !mult_stall && !flush_c;
    accept = dispatch_en && !issuequeue_full && !flush_c;
    for (int i = 0; i < DEPTH; i++) begin
      wq[i] = q[i];
      if (cdb_valid && q[i].v && !q[i].rs_rdy && q[i].rs_tag == cdb_tag) begin
        wq[i].rs_rdy = 1'b1;
        wq[i].rs_data = cdb_data;
      end
      if (cdb_valid && q[i].v && !q[i].rt_rdy && q[i].rt_tag == cdb_tag) begin
        wq[i].rt_rdy = 1'b1;
        wq[i].rt_data = cdb_data;
      end
    end
    din.v = 1'b1;
    din.rs_tag = dispatch_rstag;
    din.rs_rdy = dispatch_rsready || (cdb_valid && cdb_tag == dispatch_rstag);
    din.rs_data = dispatch_rsready ? dispatch_rsdata : cdb_data;
    din.rt_tag = dispatch_rttag;
    din.rt_rdy = dispatch_rtready || (cdb_valid && cdb_tag == dispatch_rttag);
    din.rt_data = dispatch_rtready ? dispatch_rtdata : cdb_data;
    din.rd_tag = dispatch_rdtag;
    for (int i = 0; i < DEPTH; i++)
      nq[i] = (issue && i >= int'(sel)) ? ((i == DEPTH - 1) ? '0 : wq[(i + 1) % DEPTH]) : wq[i];
    wr_idx = IW'(issuequeue_count - CW'(issue));
    if (accept) nq[wr_idx] = din;
    if (flush_c)
      for (int i = 0; i < DEPTH; i++) nq[i] = '0;
    count_next = flush_c ? '0 : issuequeue_count + CW'(accept) - CW'(issue);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      issuequeue_count <= '0;
      issuequeue_full <= 1'b0;
      issuemult_enable <= 1'b0;
      issuemult_rsdata <= '0;
      issuemult_rtdata <= '0;
      issuemult_rdtag <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      issuequeue_count <= count_next;
      issuequeue_full <= count_next == CW'(DEPTH);
      issuemult_enable <= issue;
      if (issue) begin
        issuemult_rsdata <= q[sel].rs_data;
        issuemult_rtdata <= q[sel].rt_data;
        issuemult_rdtag <= q[sel].rd_tag;
      end
    end
  end
endmodule
